// File: rtl/micro_pkg.sv
// Shared types and control-store address map
// for the microprogram sequencer.
package micro_pkg;

  typedef enum logic [2:0] {
    SEQ_NEXT  = 3'd0,
    SEQ_JUMP  = 3'd1,
    SEQ_DISP1 = 3'd2,
    SEQ_DISP2 = 3'd3,
    SEQ_CALL  = 3'd4,
    SEQ_RET   = 3'd5,
    SEQ_FETCH = 3'd6,
    SEQ_HALT  = 3'd7
  } useq_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_UNF  = 2'd2,
    ERR_TMO  = 2'd3
  } err_code_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } mode_t;

  localparam int FETCH_ADR   = 0;
  localparam int DISP1_DP    = 6;
  localparam int DISP1_MEM   = 2;
  localparam int DISP1_BR    = 9;
  localparam int DISP2_LDR   = 3;
  localparam int DISP2_STR   = 5;
  localparam int DISP2_DPREG = 7;
  localparam int DISP2_DPIMM = 8;

  // The trap address is the top of the control store.
  function automatic int err_adr(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/micro_return_stack.sv
// Micro-return address stack with push/pop/clear
// and full/empty flags.
module micro_return_stack
  import micro_pkg::*;
#(
  parameter int W     = 6,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int SP_W = $clog2(DEPTH + 1);

  logic [W-1:0]    mem [DEPTH];
  logic [SP_W-1:0] sp;

  assign full  = (sp == SP_W'(DEPTH));
  assign empty = (sp == '0);

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (SP_W'(i + 1) == sp) top = mem[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      sp <= '0;
    end else if (push && !full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (SP_W'(i) == sp) mem[i] <= din;
      end
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

endmodule

// File: rtl/microcode_sequencer.sv
// Control-store address sequencer for the multicycle
// control unit: branch, dispatch, call/return, stall.
module microcode_sequencer
  import micro_pkg::*;
#(
  parameter int UADDR_W     = 6,
  parameter int STACK_DEPTH = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         useq,
  input  logic [UADDR_W-1:0] ujump,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               mem_req,
  input  logic               mem_ready,
  output logic [UADDR_W-1:0] uadr,
  output logic               stalled,
  output logic               instr_done,
  output logic               halted,
  output logic               err,
  output logic [1:0]         err_code
);

  localparam logic [UADDR_W-1:0] A_ERR =
    UADDR_W'(err_adr(UADDR_W));
  localparam logic [UADDR_W-1:0] A_FETCH =
    UADDR_W'(FETCH_ADR);

  mode_t              mode, mode_n;
  err_code_t          code, code_n;
  logic [UADDR_W-1:0] uadr_n, uadr_inc;
  logic [7:0]         cnt, cnt_n;
  logic               done_n;
  logic               push, pop, clr;
  logic [UADDR_W-1:0] stk_top;
  logic               stk_full, stk_empty;

  assign uadr_inc   = uadr + 1'b1;
  assign halted     = (mode == ST_HALT);
  assign err        = (mode == ST_ERR);
  assign err_code   = code;
  assign stalled    = mem_req && !mem_ready &&
                      !halted && !err;

  micro_return_stack #(
    .W     (UADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (clr),
    .din   (uadr_inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mode       <= ST_RUN;
      code       <= ERR_NONE;
      uadr       <= A_FETCH;
      cnt        <= '0;
      instr_done <= 1'b0;
    end else begin
      mode       <= mode_n;
      code       <= code_n;
      uadr       <= uadr_n;
      cnt        <= cnt_n;
      instr_done <= done_n;
    end
  end

  always_comb begin
    mode_n = mode;
    code_n = code;
    uadr_n = uadr;
    cnt_n  = cnt;
    done_n = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    clr    = 1'b0;
    if (mode == ST_RUN) begin
      if (stalled) begin
        // The cycle that completes TIMEOUT stalls traps.
        if (cnt >= 8'(TIMEOUT - 1)) begin
          mode_n = ST_ERR;
          code_n = ERR_TMO;
          uadr_n = A_ERR;
        end else if (cnt != 8'hFF) begin
          cnt_n = cnt + 8'd1;
        end
      end else begin
        cnt_n = '0;
        unique case (useq_t'(useq))
          SEQ_NEXT: uadr_n = uadr_inc;
          SEQ_JUMP: uadr_n = ujump;
          SEQ_DISP1: begin
            unique case (Op)
              2'b00: uadr_n = UADDR_W'(DISP1_DP);
              2'b01: uadr_n = UADDR_W'(DISP1_MEM);
              2'b10: uadr_n = UADDR_W'(DISP1_BR);
              default: uadr_n = A_ERR;
            endcase
          end
          SEQ_DISP2: begin
            unique case (1'b1)
              (Op == 2'b01):
                uadr_n = Funct[0] ?
                  UADDR_W'(DISP2_LDR) :
                  UADDR_W'(DISP2_STR);
              (Op == 2'b00):
                uadr_n = Funct[5] ?
                  UADDR_W'(DISP2_DPIMM) :
                  UADDR_W'(DISP2_DPREG);
              default: uadr_n = A_ERR;
            endcase
          end
          SEQ_CALL: begin
            if (stk_full) begin
              mode_n = ST_ERR;
              code_n = ERR_OVF;
              uadr_n = A_ERR;
            end else begin
              push   = 1'b1;
              uadr_n = ujump;
            end
          end
          SEQ_RET: begin
            if (stk_empty) begin
              mode_n = ST_ERR;
              code_n = ERR_UNF;
              uadr_n = A_ERR;
            end else begin
              pop    = 1'b1;
              uadr_n = stk_top;
            end
          end
          SEQ_FETCH: begin
            clr    = 1'b1;
            uadr_n = A_FETCH;
            done_n = 1'b1;
          end
          SEQ_HALT: mode_n = ST_HALT;
          default: uadr_n = uadr;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench: directed scenarios plus random
// stimulus against a queue-based reference model.
module tb_microcode_sequencer;

  localparam int AW  = 6;
  localparam int DEP = 2;
  localparam int TMO = 15;
  localparam int ERA = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    useq;
  logic [AW-1:0] ujump;
  logic [1:0]    Op;
  logic [5:0]    Funct;
  logic          mem_req, mem_ready;
  logic [AW-1:0] uadr;
  logic          stalled, instr_done, halted, err;
  logic [1:0]    err_code;

  int vectors = 0;
  int miscompares = 0;

  int m_uadr, m_cnt, m_code;
  bit m_halt, m_err, m_done, m_st;
  int m_stack[$];
  logic st_obs;

  always #5 clk = ~clk;

  microcode_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .useq       (useq),
    .ujump      (ujump),
    .Op         (Op),
    .Funct      (Funct),
    .mem_req    (mem_req),
    .mem_ready  (mem_ready),
    .uadr       (uadr),
    .stalled    (stalled),
    .instr_done (instr_done),
    .halted     (halted),
    .err        (err),
    .err_code   (err_code)
  );

  task automatic model_reset();
    m_uadr = 0; m_cnt = 0; m_code = 0;
    m_halt = 0; m_err = 0; m_done = 0;
    m_stack.delete();
  endtask

  task automatic model_step(input int q, input int j,
                            input int o, input int f,
                            input bit rq, input bit rd);
    m_st = rq && !rd && !m_halt && !m_err;
    m_done = 0;
    if (m_halt || m_err) return;
    if (m_st) begin
      m_cnt++;
      if (m_cnt >= TMO) begin
        m_err = 1; m_code = 3; m_uadr = ERA;
      end
      return;
    end
    m_cnt = 0;
    case (q)
      0: m_uadr = (m_uadr + 1) % (1 << AW);
      1: m_uadr = j;
      2: m_uadr = (o == 0) ? 6 : (o == 1) ? 2 :
                  (o == 2) ? 9 : ERA;
      3: begin
        if (o == 1) m_uadr = f[0] ? 3 : 5;
        else if (o == 0) m_uadr = f[5] ? 8 : 7;
        else m_uadr = ERA;
      end
      4: begin
        if (m_stack.size() == DEP) begin
          m_err = 1; m_code = 1; m_uadr = ERA;
        end else begin
          m_stack.push_back((m_uadr + 1) % (1 << AW));
          m_uadr = j;
        end
      end
      5: begin
        if (m_stack.size() == 0) begin
          m_err = 1; m_code = 2; m_uadr = ERA;
        end else begin
          m_uadr = m_stack.pop_back();
        end
      end
      6: begin
        m_uadr = 0; m_stack.delete(); m_done = 1;
      end
      default: m_halt = 1;
    endcase
  endtask

  // Drive one cycle's inputs; st_obs holds stalled
  // as seen before the clock edge.
  task automatic step(input int q, input int j,
                      input int o, input int f,
                      input bit rq, input bit rd);
    useq = 3'(q); ujump = AW'(j);
    Op = 2'(o); Funct = 6'(f);
    mem_req = rq; mem_ready = rd;
    #1 st_obs = stalled;
    model_step(q, j, o, f, rq, rd);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    useq = 3'd0; ujump = '0; Op = '0; Funct = '0;
    mem_req = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({uadr, instr_done, halted, err, err_code,
         stalled} !== {6'd0, 1'b0, 1'b0, 1'b0, 2'd0,
         1'b0}) begin
      miscompares++;
      $display("FAIL reset: uadr=%0d done=%b halt=%b err=%b code=%0d stl=%b want all 0",
               uadr, instr_done, halted, err, err_code,
               stalled);
    end
  endtask

  task automatic test_next();
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 0, 0, 1);
      vectors++;
      if (uadr !== AW'(i) || instr_done !== 1'b0 ||
          err !== 1'b0) begin
        miscompares++;
        $display("FAIL next: uadr=%0d done=%b err=%b want %0d 0 0",
                 uadr, instr_done, err, i);
      end
    end
  endtask

  task automatic test_dispatch();
    do_reset();
    step(2, 0, 1, 1, 0, 1);
    vectors++;
    if (uadr !== 6'd2) begin
      miscompares++;
      $display("FAIL disp1_mem: uadr=%0d want 2", uadr);
    end
    step(3, 0, 1, 1, 0, 1);
    vectors++;
    if (uadr !== 6'd3) begin
      miscompares++;
      $display("FAIL disp2_ldr: uadr=%0d want 3", uadr);
    end
    step(3, 0, 0, 32, 0, 1);
    vectors++;
    if (uadr !== 6'd8) begin
      miscompares++;
      $display("FAIL disp2_dpimm: uadr=%0d want 8", uadr);
    end
    step(2, 0, 3, 0, 0, 1);
    vectors++;
    if (uadr !== 6'(ERA) || err !== 1'b0) begin
      miscompares++;
      $display("FAIL disp1_trap: uadr=%0d err=%b want %0d 0",
               uadr, err, ERA);
    end
    step(0, 0, 0, 0, 0, 1);
    vectors++;
    if (uadr !== 6'd0) begin
      miscompares++;
      $display("FAIL next_wrap: uadr=%0d want 0", uadr);
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    step(1, 4, 0, 0, 0, 1);
    step(4, 20, 0, 0, 0, 1);
    vectors++;
    if (uadr !== 6'd20) begin
      miscompares++;
      $display("FAIL call: uadr=%0d want 20", uadr);
    end
    step(5, 0, 0, 0, 0, 1);
    vectors++;
    if (uadr !== 6'd5) begin
      miscompares++;
      $display("FAIL ret: uadr=%0d want 5", uadr);
    end
    step(4, 10, 0, 0, 0, 1);
    step(4, 30, 0, 0, 0, 1);
    step(4, 40, 0, 0, 0, 1);
    vectors++;
    if (err !== 1'b1 || err_code !== 2'd1 ||
        uadr !== 6'(ERA)) begin
      miscompares++;
      $display("FAIL overflow: err=%b code=%0d uadr=%0d want 1 1 %0d",
               err, err_code, uadr, ERA);
    end
    step(5, 0, 0, 0, 1, 0);
    vectors++;
    if (err_code !== 2'd1 || uadr !== 6'(ERA)) begin
      miscompares++;
      $display("FAIL err_sticky: code=%0d uadr=%0d want 1 %0d",
               err_code, uadr, ERA);
    end
    do_reset();
    step(5, 0, 0, 0, 0, 1);
    vectors++;
    if (err !== 1'b1 || err_code !== 2'd2) begin
      miscompares++;
      $display("FAIL underflow: err=%b code=%0d want 1 2",
               err, err_code);
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(1, 3, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 1, 0);
      vectors++;
      if (uadr !== 6'd3 || st_obs !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_hold: uadr=%0d stalled=%b want 3 1",
                 uadr, st_obs);
      end
    end
    step(0, 0, 0, 0, 1, 1);
    vectors++;
    if (uadr !== 6'd4 || st_obs !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_release: uadr=%0d stalled=%b want 4 0",
               uadr, st_obs);
    end
    for (int i = 0; i < TMO - 1; i++) step(0, 0, 0, 0, 1, 0);
    vectors++;
    if (err !== 1'b0 || uadr !== 6'd4) begin
      miscompares++;
      $display("FAIL pre_timeout: err=%b uadr=%0d want 0 4",
               err, uadr);
    end
    step(0, 0, 0, 0, 1, 0);
    vectors++;
    if (err !== 1'b1 || err_code !== 2'd3 ||
        uadr !== 6'(ERA) || stalled !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout: err=%b code=%0d uadr=%0d stl=%b want 1 3 %0d 0",
               err, err_code, uadr, stalled, ERA);
    end
  endtask

  task automatic test_fetch_halt();
    do_reset();
    step(1, 9, 0, 0, 0, 1);
    step(6, 0, 0, 0, 0, 1);
    vectors++;
    if (uadr !== 6'd0 || instr_done !== 1'b1) begin
      miscompares++;
      $display("FAIL fetch: uadr=%0d done=%b want 0 1",
               uadr, instr_done);
    end
    step(0, 0, 0, 0, 0, 1);
    vectors++;
    if (uadr !== 6'd1 || instr_done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse: uadr=%0d done=%b want 1 0",
               uadr, instr_done);
    end
    step(7, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    vectors++;
    if (halted !== 1'b1 || uadr !== 6'd1) begin
      miscompares++;
      $display("FAIL halt: halted=%b uadr=%0d want 1 1",
               halted, uadr);
    end
    step(4, 12, 0, 0, 0, 1);
    do_reset();
    vectors++;
    if ({uadr, instr_done, halted, err, err_code} !==
        {6'd0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_after_halt: uadr=%0d halt=%b err=%b code=%0d want 0 0 0 0",
               uadr, halted, err, err_code);
    end
    step(5, 0, 0, 0, 0, 1);
    vectors++;
    if (err_code !== 2'd2) begin
      miscompares++;
      $display("FAIL stack_cleared: code=%0d want 2", err_code);
    end
  endtask

  task automatic test_random();
    int q, j, o, f;
    bit rq, rd;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ((m_err || m_halt) && $urandom_range(0, 3) == 0)
        do_reset();
      q  = $urandom_range(0, 99);
      q  = (q < 30) ? 0 : (q < 45) ? 1 : (q < 55) ? 2 :
           (q < 65) ? 3 : (q < 78) ? 4 : (q < 90) ? 5 :
           (q < 97) ? 6 : 7;
      j  = $urandom_range(0, ERA);
      o  = $urandom_range(0, 3);
      f  = $urandom_range(0, 63);
      rq = $urandom_range(0, 1);
      rd = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 40) == 0) begin
        for (int k = 0; k < TMO; k++) step(q, j, o, f, 1, 0);
      end
      step(q, j, o, f, rq, rd);
      vectors++;
      if (st_obs !== m_st || uadr !== AW'(m_uadr) ||
          instr_done !== m_done || halted !== m_halt ||
          err !== m_err || err_code !== 2'(m_code)) begin
        miscompares++;
        $display("FAIL random[%0d]: stl=%b uadr=%0d done=%b halt=%b err=%b code=%0d want %b %0d %b %b %b %0d",
                 n, st_obs, uadr, instr_done, halted, err,
                 err_code, m_st, m_uadr, m_done, m_halt,
                 m_err, m_code);
      end
    end
  endtask

  initial begin
    test_reset();
    test_next();
    test_dispatch();
    test_call_ret();
    test_stall();
    test_fetch_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Microprogram sequencer for the multicycle ARM control unit. Drives the control-store address `uadr` each cycle.
- Next address is chosen from the sequencing field of the current microword: increment, jump, two-level dispatch on Op/Funct, subroutine call/return, fetch restart or halt.
- Stalls on memory wait states, with a watchdog.
- Sits between the control memory (combinational, indexed by `uadr`) and the control buffer register.

Parameters:
- UADDR_W, 6, control-store address width.
- STACK_DEPTH, 2, micro-return stack entries (1..4).
- TIMEOUT, 15, max consecutive stall cycles before error (1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- useq  in  3  sequencing field of current microword
- ujump  in  UADDR_W  jump/call target field of current microword
- Op  in  2  instruction Op field (from IR)
- Funct  in  6  instruction Funct field (from IR)
- mem_req  in  1  current microword accesses memory
- mem_ready  in  1  memory completes access this cycle
- uadr  out  UADDR_W  registered control-store address
- stalled  out  1  combinational: mem_req && !mem_ready && !halted && !err
- instr_done  out  1  registered 1-cycle pulse after a SEQ_FETCH step
- halted  out  1  registered, sticky until reset
- err  out  1  registered, sticky until reset
- err_code  out  2  registered: 0 none, 1 stack overflow, 2 stack underflow, 3 stall timeout

Behaviour:
Reset (sync, active-high) sets:
- uadr=FETCH_ADR(0), stack empty, sp=0, stall_cnt=0
- instr_done=0, halted=0, err=0, err_code=0

Advance condition:
- uadr updates only when not stalled, not halted, not err.
- While stalled: uadr holds and stall_cnt increments (saturating).
- When stall_cnt reaches TIMEOUT with the stall still present: err=1, err_code=3, uadr=ERR_ADR.
- stall_cnt clears on any non-stalled cycle.

useq encodings (advancing cycle):
- 0 NEXT: uadr+1, modulo 2^UADDR_W (wraps to 0).
- 1 JUMP: uadr=ujump.
- 2 DISP1 (on Op): 00 -> DISP1_DP, 01 -> DISP1_MEM, 10 -> DISP1_BR, 11 -> ERR_ADR. Op=11 keeps err=0 and is a microcode-visible trap.
- 3 DISP2 (Op/Funct): Op=01 -> Funct[0] ? DISP2_LDR : DISP2_STR; Op=00 -> Funct[5] ? DISP2_DPIMM : DISP2_DPREG; Op=1x -> ERR_ADR.
- 4 CALL: push uadr+1 (wrapped), uadr=ujump. If stack full: err=1, err_code=1, uadr=ERR_ADR, no push.
- 5 RET: pop into uadr. If stack empty: err=1, err_code=2, uadr=ERR_ADR.
- 6 FETCH: uadr=FETCH_ADR, stack cleared, instr_done=1 next cycle.
- 7 HALT: halted=1, uadr holds.

Priority and error handling:
- Error has priority: the first error latches err_code, and later events do not overwrite it.
- Once err=1, uadr stays at ERR_ADR.
- Reset mid-stall or mid-subroutine is fully restoring: stack and counters are cleared.
- instr_done is 0 in all other cycles.

Latency:
- Next address is visible the cycle after the step, so one microinstruction executes per advancing cycle.

Decomposition:
- Package `micro_pkg` holds:
  - the useq_t enum (SEQ_NEXT..SEQ_HALT)
  - err_code_t
  - address constants FETCH_ADR=0, DISP1_DP=6, DISP1_MEM=2, DISP1_BR=9, DISP2_LDR=3, DISP2_STR=5, DISP2_DPREG=7, DISP2_DPIMM=8, ERR_ADR=2^UADDR_W-1
- One sub-module: `micro_return_stack` (push/pop/clear, full/empty flags, synchronous reset).
- Dispatch decoding stays inline.

Test Plan:
- Reset, then useq=NEXT for 3 cycles -> uadr 0,1,2,3; instr_done=0; err=0.
- Op=01, Funct[0]=1; useq=DISP1, then DISP2 -> uadr=2, then 3. With Op=11 and DISP1 -> uadr=ERR_ADR, err=0.
- From uadr=4: CALL ujump=20 -> uadr=20. RET -> uadr=5. CALL three times with STACK_DEPTH=2 -> third call gives err=1, err_code=1, uadr=ERR_ADR.
- mem_req=1, mem_ready=0 for 5 cycles at uadr=3 -> uadr holds at 3 and stalled=1. mem_ready=1 with NEXT -> uadr=4. Holding mem_ready=0 for TIMEOUT cycles -> err_code=3.
- FETCH at uadr=9 -> uadr=0 and instr_done pulses for exactly 1 cycle. HALT -> halted=1 and uadr frozen. Assert reset for 1 cycle -> all outputs back to reset values.
